// File: rtl/axi_lite_regfile_if.sv
`default_nettype none
// =============================================================================
// Module   : AXI_LITE
// Brief    : AXI4-Lite bus bundle with master and slave views.
// Revision : 1.0
// =============================================================================
interface AXI_LITE;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, wlast, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, wlast, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, rlast
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// =============================================================================
// Module   : axi_lite_regfile
// Brief    : AXI4-Lite slave exposing NUM_REGS 32-bit byte-writable registers.
// Revision : 1.0
// =============================================================================
module axi_lite_regfile #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     resetn,
    AXI_LITE.slave                   axi_slave,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic                     wr_pulse_o,
    output logic [7:0]               wr_idx_o
);

    localparam int          c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] c_SPAN  = 32'(4 * NUM_REGS);

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // Offset compare also rejects addresses below BASE_ADDR via unsigned wrap.
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (off < c_SPAN);
    endfunction

    function automatic logic [c_IDX_W-1:0] reg_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[c_IDX_W+1:2];
    endfunction

    logic [31:0]        r_regs [NUM_REGS];
    wstate_t            r_wstate, w_wstate_nxt;
    rstate_t            r_rstate, w_rstate_nxt;
    logic [31:0]        r_awaddr, r_wdata, r_rdata;
    logic [3:0]         r_wstrb;
    logic [1:0]         r_bresp, r_rresp;
    logic               r_wr_pulse;
    logic [7:0]         r_wr_idx;

    logic               w_awready, w_wready, w_arready;
    logic               w_commit, w_latch_aw, w_latch_w, w_capture;
    logic [31:0]        w_c_addr, w_c_data;
    logic [3:0]         w_c_strb;
    logic [c_IDX_W-1:0] w_c_idx;
    logic               w_unused;

    assign w_unused = axi_slave.wlast;
    assign w_c_idx  = reg_idx(w_c_addr);

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_commit     = 1'b0;
        w_latch_aw   = 1'b0;
        w_latch_w    = 1'b0;
        w_c_addr     = r_awaddr;
        w_c_data     = r_wdata;
        w_c_strb     = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                w_wready  = 1'b1;
                if (axi_slave.awvalid && axi_slave.wvalid) begin
                    w_commit     = 1'b1;
                    w_c_addr     = axi_slave.awaddr;
                    w_c_data     = axi_slave.wdata;
                    w_c_strb     = axi_slave.wstrb;
                    w_wstate_nxt = W_RESP;
                end else if (axi_slave.awvalid) begin
                    w_latch_aw   = 1'b1;
                    w_wstate_nxt = W_HAVE_AW;
                end else if (axi_slave.wvalid) begin
                    w_latch_w    = 1'b1;
                    w_wstate_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                w_wready = 1'b1;
                if (axi_slave.wvalid) begin
                    w_commit     = 1'b1;
                    w_c_data     = axi_slave.wdata;
                    w_c_strb     = axi_slave.wstrb;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_HAVE_W: begin
                w_awready = 1'b1;
                if (axi_slave.awvalid) begin
                    w_commit     = 1'b1;
                    w_c_addr     = axi_slave.awaddr;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_slave.bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        // Readies drop as soon as reset is asserted, not one edge later.
        if (!resetn) begin
            w_awready = 1'b0;
            w_wready  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) r_wstate <= W_IDLE;
        else         r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            if (w_latch_aw) r_awaddr <= axi_slave.awaddr;
            if (w_latch_w) begin
                r_wdata <= axi_slave.wdata;
                r_wstrb <= axi_slave.wstrb;
            end
            if (w_commit) begin
                r_bresp <= in_range(w_c_addr) ? 2'b00 : 2'b10;
                if (in_range(w_c_addr) && (w_c_strb != 4'h0)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_c_strb[b]) r_regs[w_c_idx][8*b +: 8] <= w_c_data[8*b +: 8];
                    end
                    r_wr_pulse <= 1'b1;
                    r_wr_idx   <= 8'(w_c_idx);
                end
            end
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_capture    = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                w_arready = 1'b1;
                if (axi_slave.arvalid) begin
                    w_capture    = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_slave.rready) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (!resetn) w_arready = 1'b0;
    end

    // Capture reads the pre-commit register value on a same-edge write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_capture) begin
                r_rdata <= in_range(axi_slave.araddr) ? r_regs[reg_idx(axi_slave.araddr)] : 32'h0;
                r_rresp <= in_range(axi_slave.araddr) ? 2'b00 : 2'b10;
            end
        end
    end

    assign axi_slave.awready = w_awready;
    assign axi_slave.wready  = w_wready;
    assign axi_slave.bvalid  = (r_wstate == W_RESP);
    assign axi_slave.bresp   = r_bresp;
    assign axi_slave.arready = w_arready;
    assign axi_slave.rvalid  = (r_rstate == R_DATA);
    assign axi_slave.rlast   = (r_rstate == R_DATA);
    assign axi_slave.rdata   = r_rdata;
    assign axi_slave.rresp   = r_rresp;
    assign wr_pulse_o        = r_wr_pulse;
    assign wr_idx_o          = r_wr_idx;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
            assign regs_o[32*i +: 32] = r_regs[i];
        end
    endgenerate

endmodule
`default_nettype wire
